fir_output_serializer: RTL and testbench

Hardware capture end of the FIR filter datapath: accepts the 40-bit signed filter output (one sample per qualified clock), buffers samples in a small FIFO, and streams each sample out as five bytes, MSB first, over an 8-bit valid/ready interface. It sits between the Tree_Adder / direct-form filter output and the off-chip logging link. It replaces the testbench's per-cycle file write with synthesizable capture logic.

---
 rtl/fir_output_serializer.sv | 121 ++++++++++++
 tb/tb_fir_output_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_serializer.sv
// fir_output_serializer
// Capture end of the FIR datapath: queues signed filter samples in a small
// FIFO and streams each one out as BYTES bytes, MSB first, over an 8-bit
// valid/ready link. byte_last95 marks the LSB byte of every sample.
module fir_output_serializer #(
  parameter  int DATA_W = 40,
  parameter  int DEPTH  = 8,
  localparam int BYTES  = DATA_W / 8
) (
  input  logic                       clock95,
  input  logic                       reset95,
  input  logic signed [DATA_W-1:0]   sample_in95,
  input  logic                       sample_valid95,
  output logic [7:0]                 byte_out95,
  output logic                       byte_valid95,
  input  logic                       byte_ready95,
  output logic                       byte_last95,
  output logic [$clog2(DEPTH):0]     fifo_count95,
  output logic                       overflow95
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Sample storage and FIFO bookkeeping. The count is kept separately from
  // the pointers so that full and empty never alias.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  // Serializer state: the sample being sent and which byte is on the bus.
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_hs;
  logic w_last;
  logic w_pop;

  // Full is judged on the pre-edge count, so a pop on the same edge never
  // makes room for an incoming sample.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = sample_valid95 & ~w_full;
  assign w_hs    = (r_state == ST_SEND) & byte_ready95;
  assign w_last  = (r_idx == IW'(BYTES - 1));
  // Load a new sample when idle, or back-to-back on the final handshake.
  assign w_pop   = ~w_empty & ((r_state == ST_IDLE) | (w_hs & w_last));

  // Next-state selection for the IDLE/SEND controller.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty)                  w_state_nxt = ST_SEND;
      ST_SEND: if (w_hs && w_last && w_empty) w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage write.
  // NOTE: the sample array has no reset; contents are only ever read behind a
  // non-zero count, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clock95) begin
    if (w_push) r_mem[r_wr_ptr] <= sample_in95;
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clock95 or negedge reset95) begin
    if (!reset95) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (sample_valid95 && w_full) r_overflow <= 1'b1;
    end
  end

  // Controller state, shift register and byte index.
  always_ff @(posedge clock95 or negedge reset95) begin
    if (!reset95) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_idx   <= '0;
      end else if (w_hs && !w_last) begin
        r_shift <= {r_shift[DATA_W-9:0], 8'h00};
        r_idx   <= r_idx + IW'(1);
      end
    end
  end

  // Outputs come straight from registers, so they hold under backpressure
  // and take their reset values as soon as reset95 falls.
  assign byte_valid95 = (r_state == ST_SEND);
  assign byte_out95   = r_shift[DATA_W-1 -: 8];
  assign byte_last95  = byte_valid95 & w_last;
  assign fifo_count95 = r_count;
  assign overflow95   = r_overflow;

endmodule

// File: tb/tb_fir_output_serializer.sv
// Directed bench for fir_output_serializer: single sample, back-to-back
// negative values, backpressure, overflow, full-FIFO push/pop and reset
// in the middle of a frame.
module tb_fir_output_serializer;

  localparam int DATA_W = 40;
  localparam int DEPTH  = 8;

  logic                     clock95 = 1'b0;
  logic                     reset95;
  logic signed [DATA_W-1:0] sample_in95;
  logic                     sample_valid95;
  logic [7:0]               byte_out95;
  logic                     byte_valid95;
  logic                     byte_ready95;
  logic                     byte_last95;
  logic [3:0]               fifo_count95;
  logic                     overflow95;

  int total = 0;
  int bad   = 0;

  fir_output_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock95        (clock95),
    .reset95        (reset95),
    .sample_in95    (sample_in95),
    .sample_valid95 (sample_valid95),
    .byte_out95     (byte_out95),
    .byte_valid95   (byte_valid95),
    .byte_ready95   (byte_ready95),
    .byte_last95    (byte_last95),
    .fifo_count95   (fifo_count95),
    .overflow95     (overflow95)
  );

  always #5 clock95 = ~clock95;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clock95);
    #1;
  endtask

  // Expects the byte stream of one sample to start now with ready held high.
  task automatic expect_sample(input string tag, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] s;
    s = v;
    byte_ready95 = 1'b1;
    for (int i = 0; i < DATA_W / 8; i++) begin
      chk({tag, " valid"}, 64'(byte_valid95), 64'(1));
      chk({tag, " byte"},  64'(byte_out95),   64'(s[DATA_W-1 -: 8]));
      chk({tag, " last"},  64'(byte_last95),  64'(i == DATA_W / 8 - 1));
      s = s << 8;
      step();
    end
  endtask

  logic [7:0] bp_exp [8];
  logic       bp_rdy [8];

  initial begin
    reset95        = 1'b0;
    sample_in95    = '0;
    sample_valid95 = 1'b0;
    byte_ready95   = 1'b0;

    // ---- reset state ----
    #12;
    chk("rst valid", 64'(byte_valid95), 64'(0));
    chk("rst byte",  64'(byte_out95),   64'(0));
    chk("rst last",  64'(byte_last95),  64'(0));
    chk("rst count", 64'(fifo_count95), 64'(0));
    chk("rst ovf",   64'(overflow95),   64'(0));
    reset95 = 1'b1;
    step();

    // ---- single sample ----
    sample_in95    = 40'sh12_3456_789A;
    sample_valid95 = 1'b1;
    byte_ready95   = 1'b1;
    step();
    sample_valid95 = 1'b0;
    chk("single count E",  64'(fifo_count95), 64'(1));
    chk("single valid E",  64'(byte_valid95), 64'(0));
    step();
    chk("single count E1", 64'(fifo_count95), 64'(0));
    expect_sample("single", 40'h12_3456_789A);
    chk("single idle", 64'(byte_valid95), 64'(0));

    // ---- back-to-back negative values, no bubble ----
    sample_in95    = -40'sd1;
    sample_valid95 = 1'b1;
    step();
    chk("b2b count E", 64'(fifo_count95), 64'(1));
    sample_in95 = 40'sh80_0000_0000;
    step();
    sample_valid95 = 1'b0;
    chk("b2b count E1", 64'(fifo_count95), 64'(1));
    expect_sample("neg1", 40'hFF_FFFF_FFFF);
    expect_sample("min",  40'h80_0000_0000);
    chk("b2b idle",  64'(byte_valid95), 64'(0));
    chk("b2b count", 64'(fifo_count95), 64'(0));

    // ---- backpressure ----
    bp_exp = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04, 8'h05};
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    sample_in95    = 40'sh01_0203_0405;
    sample_valid95 = 1'b1;
    step();
    sample_valid95 = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      byte_ready95 = bp_rdy[i];
      chk($sformatf("bp valid %0d", i), 64'(byte_valid95), 64'(1));
      chk($sformatf("bp byte %0d", i),  64'(byte_out95),   64'(bp_exp[i]));
      chk($sformatf("bp last %0d", i),  64'(byte_last95),  64'(i == 7));
      step();
    end
    chk("bp idle", 64'(byte_valid95), 64'(0));

    // ---- overflow: ten pushes with the sink stalled ----
    // Sample 1 leaves for the shift register on the second edge, so the
    // FIFO reaches 8 on push 9 and push 10 is the one dropped.
    byte_ready95 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      sample_in95    = 40'(k);
      sample_valid95 = 1'b1;
      step();
      chk($sformatf("ovf count %0d", k), 64'(fifo_count95),
          64'((k == 1) ? 1 : ((k >= 9) ? 8 : k - 1)));
      chk($sformatf("ovf flag %0d", k), 64'(overflow95), 64'(k == 10));
    end
    sample_valid95 = 1'b0;
    chk("ovf valid held", 64'(byte_valid95), 64'(1));

    // Drain sample 1; push on its last-byte edge with the FIFO still full.
    byte_ready95 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s1 byte %0d", i), 64'(byte_out95), 64'(0));
      step();
    end
    chk("s1 last byte", 64'(byte_out95),  64'(8'h01));
    chk("s1 last flag", 64'(byte_last95), 64'(1));
    sample_in95    = 40'sh00_0000_DEAD;
    sample_valid95 = 1'b1;
    step();
    sample_valid95 = 1'b0;
    chk("full pushpop count", 64'(fifo_count95), 64'(DEPTH - 1));
    chk("full pushpop ovf",   64'(overflow95),   64'(1));
    for (int k = 2; k <= 9; k++) expect_sample($sformatf("ovf s%0d", k), 40'(k));
    chk("ovf drained valid", 64'(byte_valid95), 64'(0));
    chk("ovf drained count", 64'(fifo_count95), 64'(0));
    chk("ovf sticky",        64'(overflow95),   64'(1));

    // ---- reset mid-frame ----
    byte_ready95   = 1'b0;
    sample_in95    = 40'shAA_BBCC_DDEE;
    sample_valid95 = 1'b1;
    step();
    sample_in95 = 40'sh11; step();
    sample_in95 = 40'sh22; step();
    sample_in95 = 40'sh33; step();
    sample_valid95 = 1'b0;
    chk("mid count", 64'(fifo_count95), 64'(3));
    byte_ready95 = 1'b1;
    chk("mid byte0", 64'(byte_out95), 64'(8'hAA));
    step();
    chk("mid byte1", 64'(byte_out95), 64'(8'hBB));
    step();
    reset95 = 1'b0;
    #1;
    chk("mid rst valid", 64'(byte_valid95), 64'(0));
    chk("mid rst byte",  64'(byte_out95),   64'(0));
    chk("mid rst last",  64'(byte_last95),  64'(0));
    chk("mid rst count", 64'(fifo_count95), 64'(0));
    chk("mid rst ovf",   64'(overflow95),   64'(0));
    step();
    reset95 = 1'b1;
    step();
    step();
    chk("post rst valid", 64'(byte_valid95), 64'(0));
    chk("post rst count", 64'(fifo_count95), 64'(0));
    sample_in95    = 40'sh1;
    sample_valid95 = 1'b1;
    step();
    sample_valid95 = 1'b0;
    step();
    expect_sample("post rst", 40'h1);
    chk("post rst idle", 64'(byte_valid95), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
